// File: rtl/program_loader.sv
// Byte-stream program loader for the single-cycle RV32I core: assembles framed
// segments into instruction/data memory writes and supervises one run at a time.
module program_loader #(
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        Instruction_Write_Enable,
    output logic [31:0] Instruction_Write,
    output logic [31:0] Instruction_Address,
    output logic [31:0] Data_write_Data,
    output logic [31:0] Data_write_Address,
    output logic        core_rst_n,
    input  logic        Finish_Prog,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        err,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_RUN   = 3'd5,
        ST_HALT  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [7:0] CMD_INSTR = 8'hA1;
    localparam logic [7:0] CMD_DATA  = 8'hA2;
    localparam logic [7:0] CMD_RUN   = 8'hA5;

    state_t      r_state;
    logic        r_ready;
    logic        r_busy;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_addr;
    logic [15:0] r_remain;
    logic        r_is_instr;
    logic        r_iwe;
    logic [31:0] r_iword;
    logic [31:0] r_iaddr;
    logic [31:0] r_dword;
    logic [31:0] r_daddr;
    logic        r_core_rst_n;
    logic        r_done;
    logic        r_timeout;
    logic        r_err;
    logic [31:0] r_run_cycles;

    logic        w_accept;
    logic [31:0] w_word;
    logic [15:0] w_count;
    logic        w_last_byte;
    logic        w_wdog;

    // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
    assign w_accept    = s_valid & s_ready;
    assign w_word      = {s_data, r_shift[31:8]};
    assign w_count     = {s_data, r_shift[31:24]};
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_wdog      = (r_run_cycles == (MAX_RUN_CYCLES - 32'd1));

    // Ready is forced low while reset is held so no byte is taken during reset.
    assign s_ready                  = r_ready & ~rst;
    assign busy                     = r_busy;
    assign Instruction_Write_Enable = r_iwe;
    assign Instruction_Write        = r_iword;
    assign Instruction_Address      = r_iaddr;
    assign Data_write_Data          = r_dword;
    assign Data_write_Address       = r_daddr;
    assign core_rst_n               = r_core_rst_n;
    assign done                     = r_done;
    assign timeout                  = r_timeout;
    assign err                      = r_err;
    assign run_cycles               = r_run_cycles;

    // Loader state machine with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 32'd0;
            r_addr       <= 32'd0;
            r_remain     <= 16'd0;
            r_is_instr   <= 1'b0;
            r_iwe        <= 1'b0;
            r_iword      <= 32'd0;
            r_iaddr      <= 32'd0;
            r_dword      <= 32'd0;
            r_daddr      <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= 1'b0;
            r_run_cycles <= 32'd0;
        end else begin
            r_iwe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_run_cycles <= 32'd0;
                        r_byte_cnt   <= 2'd0;
                        r_busy       <= 1'b1;
                        case (s_data)
                            CMD_INSTR, CMD_DATA: begin
                                r_is_instr <= (s_data == CMD_INSTR);
                                r_state    <= ST_ADDR;
                            end
                            CMD_RUN: begin
                                r_state      <= ST_RUN;
                                r_ready      <= 1'b0;
                                r_core_rst_n <= 1'b1;
                            end
                            default: begin
                                r_state <= ST_ERR;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        if (w_last_byte) begin
                            r_addr     <= w_word;
                            r_byte_cnt <= 2'd0;
                            r_state    <= ST_COUNT;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        if (r_byte_cnt == 2'd1) begin
                            r_byte_cnt <= 2'd0;
                            r_remain   <= w_count;
                            if (w_count == 16'd0) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        if (w_last_byte) begin
                            r_byte_cnt <= 2'd0;
                            r_state    <= ST_WRITE;
                            r_ready    <= 1'b0;
                            if (r_is_instr) begin
                                r_iwe   <= 1'b1;
                                r_iword <= w_word;
                                r_iaddr <= r_addr;
                            end else begin
                                r_dword <= w_word;
                                r_daddr <= r_addr;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_addr   <= r_addr + 32'd4;
                    r_remain <= r_remain - 16'd1;
                    r_ready  <= 1'b1;
                    if (r_remain == 16'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_RUN: begin
                    r_run_cycles <= r_run_cycles + 32'd1;
                    // A finish in the watchdog cycle wins, so timeout stays clear.
                    if (Finish_Prog || w_wdog) begin
                        r_state      <= ST_HALT;
                        r_core_rst_n <= 1'b0;
                        r_done       <= 1'b1;
                        r_timeout    <= ~Finish_Prog;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                ST_ERR: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized segments and runs checked against a frame-level model.
module tb_program_loader;

    localparam logic [31:0] MAX = 32'd16;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        Instruction_Write_Enable;
    logic [31:0] Instruction_Write;
    logic [31:0] Instruction_Address;
    logic [31:0] Data_write_Data;
    logic [31:0] Data_write_Address;
    logic        core_rst_n;
    logic        Finish_Prog;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        err;
    logic [31:0] run_cycles;

    int          errors;
    int          checks;
    int          pulse_cnt;
    longint      cyc;
    logic [31:0] m_iword, m_iaddr, m_dword, m_daddr;
    logic [31:0] seg_words[$];

    program_loader #(.MAX_RUN_CYCLES(MAX)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .Instruction_Write_Enable(Instruction_Write_Enable),
        .Instruction_Write(Instruction_Write), .Instruction_Address(Instruction_Address),
        .Data_write_Data(Data_write_Data), .Data_write_Address(Data_write_Address),
        .core_rst_n(core_rst_n), .Finish_Prog(Finish_Prog), .busy(busy), .done(done),
        .timeout(timeout), .err(err), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (Instruction_Write_Enable === 1'b1) pulse_cnt <= pulse_cnt + 1;

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic gap(input int c);
        s_valid = 1'b0;
        repeat (c) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        rst = 1'b1; s_valid = 1'b0; Finish_Prog = 1'b0;
        @(posedge clk); #1;
        m_iword = 32'd0; m_iaddr = 32'd0; m_dword = 32'd0; m_daddr = 32'd0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // gap_mode: 0 none, 1 random gaps, 2 three-cycle gap before byte 2 of word 0
    task automatic do_segment(input logic is_instr, input logic [31:0] base, input int gap_mode);
        int n, p0;
        logic [31:0] w, a;
        longint prev_c;
        bit gapped;
        n = seg_words.size();
        p0 = pulse_cnt;
        prev_c = 0;
        send_byte(is_instr ? 8'hA1 : 8'hA2);
        for (int k = 0; k < 4; k++) begin
            if (gap_mode == 1 && $urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
            send_byte(8'(base >> (8 * k)));
        end
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = seg_words[i];
            a = base + 32'(4 * i);
            gapped = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (gap_mode == 1 && $urandom_range(0, 3) == 0) begin
                    gapped = 1'b1; gap(int'($urandom_range(1, 3)));
                end else if (gap_mode == 2 && i == 0 && k == 2) begin
                    gapped = 1'b1; gap(3);
                end
                send_byte(8'(w >> (8 * k)));
            end
            checks++;
            if (s_ready !== 1'b0) begin
                errors++; $display("FAIL write_cycle_ready: s_ready=%b required 0", s_ready);
            end
            if (is_instr) begin
                m_iword = w; m_iaddr = a;
                checks++;
                if (Instruction_Write_Enable !== 1'b1 || Instruction_Address !== a || Instruction_Write !== w) begin
                    errors++;
                    $display("FAIL instr_write: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                             Instruction_Write_Enable, Instruction_Address, Instruction_Write, a, w);
                end
            end else begin
                m_dword = w; m_daddr = a;
                checks++;
                if (Instruction_Write_Enable !== 1'b0 || Data_write_Address !== a || Data_write_Data !== w) begin
                    errors++;
                    $display("FAIL data_write: we=%b addr=%h data=%h required we=0 addr=%h data=%h",
                             Instruction_Write_Enable, Data_write_Address, Data_write_Data, a, w);
                end
            end
            if (i > 0 && !gapped) begin
                checks++;
                if (cyc - prev_c != 64'd5) begin
                    errors++; $display("FAIL word_throughput: spacing=%0d required 5", cyc - prev_c);
                end
            end
            prev_c = cyc;
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pulse_cnt - p0 != (is_instr ? n : 0)) begin
            errors++; $display("FAIL pulse_count: got %0d required %0d", pulse_cnt - p0, is_instr ? n : 0);
        end
        checks++;
        if (Instruction_Write !== m_iword || Instruction_Address !== m_iaddr ||
            Data_write_Data !== m_dword || Data_write_Address !== m_daddr || busy !== 1'b0) begin
            errors++;
            $display("FAIL bus_hold: i=%h@%h d=%h@%h busy=%b required i=%h@%h d=%h@%h busy=0",
                     Instruction_Write, Instruction_Address, Data_write_Data, Data_write_Address, busy,
                     m_iword, m_iaddr, m_dword, m_daddr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        apply_reset();
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || core_rst_n !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 ||
            err !== 1'b0 || run_cycles !== 32'd0 || Instruction_Write_Enable !== 1'b0 ||
            Instruction_Write !== 32'd0 || Instruction_Address !== 32'd0 ||
            Data_write_Data !== 32'd0 || Data_write_Address !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b busy=%b crn=%b done=%b to=%b err=%b rc=%0d we=%b required all 0",
                     s_ready, busy, core_rst_n, done, timeout, err, run_cycles, Instruction_Write_Enable);
        end
        release_reset();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: s_ready=%b busy=%b required 1/0", s_ready, busy);
        end
    endtask

    task automatic test_instr_directed();
        seg_words = '{32'h00100513, 32'h00200593};
        do_segment(1'b1, 32'h0000_0000, 0);
    endtask

    task automatic test_data_gaps();
        seg_words = '{32'hDEADBEEF};
        do_segment(1'b0, 32'h0000_0010, 2);
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (Data_write_Address !== 32'h10 || Data_write_Data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL data_held: addr=%h data=%h required 00000010 deadbeef", Data_write_Address, Data_write_Data);
        end
    endtask

    task automatic test_random_segments();
        for (int s = 0; s < 5; s++) begin
            seg_words.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) seg_words.push_back($urandom);
            do_segment(1'($urandom_range(0, 1)), $urandom, 1);
        end
        seg_words = '{$urandom, $urandom};
        do_segment(1'b1, 32'hFFFF_FFFC, 0);
    endtask

    // f = cycle index (0 = first cycle with core_rst_n high) at which Finish_Prog is driven; -1 = never
    task automatic test_run(input int f);
        int e, bad;
        logic exp_to;
        exp_to = !(f >= 0 && f <= int'(MAX) - 1);
        e = exp_to ? int'(MAX) - 1 : f;
        bad = 0;
        send_byte(8'hA5);
        s_valid = 1'b0;
        checks++;
        if (core_rst_n !== 1'b1 || run_cycles !== 32'd0 || done !== 1'b0 || timeout !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_start: crn=%b rc=%0d done=%b to=%b rdy=%b required 1/0/0/0/0",
                     core_rst_n, run_cycles, done, timeout, s_ready);
        end
        for (int k = 0; k <= e; k++) begin
            if (core_rst_n !== 1'b1 || Data_write_Data !== m_dword || Data_write_Address !== m_daddr) bad++;
            Finish_Prog = (k == f);
            @(posedge clk); #1;
        end
        Finish_Prog = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL run_window: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (core_rst_n !== 1'b0 || done !== 1'b1 || timeout !== exp_to || run_cycles !== 32'(e + 1) || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_end: crn=%b done=%b to=%b rc=%0d busy=%b required 0/1/%b/%0d/1",
                     core_rst_n, done, timeout, run_cycles, busy, exp_to, e + 1);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || done !== 1'b1 || run_cycles !== 32'(e + 1)) begin
            errors++;
            $display("FAIL post_halt: busy=%b rdy=%b done=%b rc=%0d required 0/1/1/%0d",
                     busy, s_ready, done, run_cycles, e + 1);
        end
    endtask

    task automatic test_finish_ignored();
        Finish_Prog = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        Finish_Prog = 1'b0;
        checks++;
        if (core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL finish_ignored: crn=%b busy=%b done=%b required 0/0/1", core_rst_n, busy, done);
        end
    endtask

    task automatic test_zero_and_err();
        int p0;
        logic [31:0] base;
        p0 = pulse_cnt;
        base = $urandom;
        send_byte(8'hA1);
        checks++;
        if (done !== 1'b0 || timeout !== 1'b0 || run_cycles !== 32'd0) begin
            errors++;
            $display("FAIL cmd_clears: done=%b to=%b rc=%0d required 0/0/0", done, timeout, run_cycles);
        end
        for (int k = 0; k < 4; k++) send_byte(8'(base >> (8 * k)));
        send_byte(8'h00);
        send_byte(8'h00);
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL zero_count: busy=%b rdy=%b pulses=%0d required 0/1/0", busy, s_ready, pulse_cnt - p0);
        end
        send_byte(8'h55);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++; $display("FAIL err_entry: err=%b busy=%b rdy=%b required 1/1/1", err, busy, s_ready);
        end
        send_byte(8'hA5);
        send_byte(8'hA1);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom));
        s_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || core_rst_n !== 1'b0 || s_ready !== 1'b1 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL err_discard: err=%b crn=%b rdy=%b pulses=%0d required 1/0/1/0",
                     err, core_rst_n, s_ready, pulse_cnt - p0);
        end
        apply_reset();
        release_reset();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL err_cleared: err=%b busy=%b required 0/0", err, busy);
        end
    endtask

    task automatic test_rst_mid_run();
        send_byte(8'hA5);
        s_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        apply_reset();
        checks++;
        if (core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || err !== 1'b0 ||
            run_cycles !== 32'd0 || Instruction_Write_Enable !== 1'b0 || s_ready !== 1'b0 ||
            Data_write_Data !== 32'd0 || Data_write_Address !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_run: crn=%b busy=%b done=%b to=%b err=%b rc=%0d rdy=%b required all 0",
                     core_rst_n, busy, done, timeout, err, run_cycles, s_ready);
        end
        release_reset();
    endtask

    task automatic test_rst_mid_word();
        int p0;
        p0 = pulse_cnt;
        send_byte(8'hA1);
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        apply_reset();
        release_reset();
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (pulse_cnt != p0 || busy !== 1'b0 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_word: pulses=%0d busy=%b crn=%b required 0/0/0", pulse_cnt - p0, busy, core_rst_n);
        end
        seg_words = '{$urandom};
        do_segment(1'b1, 32'h0000_0100, 0);
    endtask

    initial begin
        errors = 0; checks = 0; pulse_cnt = 0; cyc = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; Finish_Prog = 1'b0;
        m_iword = 32'd0; m_iaddr = 32'd0; m_dword = 32'd0; m_daddr = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_instr_directed();
        test_data_gaps();
        test_random_segments();
        test_run(7);
        test_run(-1);
        test_run(int'(MAX) - 1);
        test_run(int'($urandom_range(0, 14)));
        test_finish_ignored();
        test_zero_and_err();
        test_rst_mid_run();
        test_rst_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the single-cycle RV32I CORE. Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes those words into the core's instruction-memory and data-memory load ports while holding the core in load mode. On a run command it releases the core, counts execution cycles until `Finish_Prog` or a watchdog limit, then parks the core back in load mode.

## Interface
- `MAX_RUN_CYCLES`, default 32'd1_000_000. Watchdog limit on execution cycles.
- `clk` in 1. Single clock.
- `rst` in 1. Synchronous, active-high reset.
- `s_data` in 8. Stream byte.
- `s_valid` in 1. Byte valid.
- `s_ready` out 1. Byte accepted on the rising edge where `s_valid & s_ready`.
- `Instruction_Write_Enable` out 1. Pulses to the core's instruction-memory write enable.
- `Instruction_Write` out 32. Instruction word.
- `Instruction_Address` out 32. Instruction byte address.
- `Data_write_Data` out 32. Data word.
- `Data_write_Address` out 32. Data byte address.
- `core_rst_n` out 1. Drives the core's `rst`. 0 = load mode/held, 1 = running.
- `Finish_Prog` in 1. From the core.
- `busy` out 1. High in any state other than IDLE.
- `done` out 1. Sticky: the last run ended.
- `timeout` out 1. Sticky: the last run hit `MAX_RUN_CYCLES`.
- `err` out 1. Sticky: an illegal command byte was received.
- `run_cycles` out 32. Cycles spent with `core_rst_n`=1 in the last or current run.

## Operation
- Frame format:
  - Command byte, then per command:
  - 0xA1: instruction segment.
  - 0xA2: data segment.
  - 0xA5: run, no payload.
  - Any other value: ERR.
- Segment payload:
  - 4-byte base address, LSB first.
  - 2-byte word count N, LSB first.
  - N words of 4 bytes each, LSB first.
- States:
  - IDLE: await command. 0xA1/0xA2 go to ADDR; 0xA5 goes to RUN; other values go to ERR.
  - ADDR: collect 4 bytes, then COUNT.
  - COUNT: collect 2 bytes. If N==0 go to IDLE with no writes; else go to DATA.
  - DATA: collect 4 bytes, then WRITE.
  - WRITE: single cycle that issues the write. Advance address by 4 (mod 2^32) and decrement the remaining count. Go to DATA if words remain, else IDLE.
  - RUN: `core_rst_n`=1. `run_cycles` increments each cycle. Go to HALT when `Finish_Prog`=1 is sampled, or when `run_cycles`==`MAX_RUN_CYCLES`-1 (this also sets `timeout`).
  - HALT: `core_rst_n`=0, set `done`, then go to IDLE the next cycle. `run_cycles` is frozen.
  - ERR: `s_ready`=1 and all bytes are discarded. Exit only by `rst`.
- Instruction segment writes: `Instruction_Write_Enable`=1 for exactly the WRITE cycle, with `Instruction_Write`/`Instruction_Address` valid that cycle. Both buses hold their values afterwards.
- Data segment writes: `Data_write_Data`/`Data_write_Address` are updated in the WRITE cycle and held until the next data write. The core writes data memory every cycle while in load mode, so holding the last pair must stay idempotent. These buses never change while `core_rst_n`=1.
- Accepting any command byte clears `done`, `timeout` and `run_cycles`.
- `Finish_Prog` is ignored outside RUN.

## Timing
- Reset values:
  - State IDLE.
  - All write buses and enables 0.
  - `core_rst_n`=0.
  - `done`, `timeout`, `err`, `busy` = 0.
  - `run_cycles`=0.
  - `s_ready`=0 while `rst`=1.
- `s_ready`=1 in IDLE, ADDR, COUNT, DATA and ERR; 0 in WRITE, RUN and HALT.
- Write latency: the write occurs in the cycle after the 4th byte of a word is accepted.
- Throughput: one word per 5 cycles with `s_valid` held high.
- Run start: `core_rst_n` rises in the cycle after 0xA5 is accepted.
- Run end: `core_rst_n` falls in the cycle after `Finish_Prog` is sampled. `done`=1 from that cycle onward.
- Simultaneous `Finish_Prog` and watchdog limit: treat as finish; `timeout` stays 0.
- Byte gaps (`s_valid`=0) stall in the current state; partial word and address state are kept.
- `rst` asserted mid-segment or mid-run: next cycle goes to IDLE with `core_rst_n`=0. Partial words are dropped; already-written words remain in memory.
- Address wrap: base 0xFFFFFFFC, N=2 writes to 0xFFFFFFFC and then 0x00000000.

## Test plan
- Instruction segment: A1, 00 00 00 00, 02 00, 13 05 10 00, 93 05 20 00 -> two 1-cycle pulses. First pulse: address 0x0, data 0x00100513. Second pulse: address 0x4, data 0x00200593. `s_ready`=0 on each pulse cycle.
- Data segment with gaps: A2, 10 00 00 00, 01 00, EF BE AD DE, with `s_valid` dropped for 3 cycles mid-word -> `Data_write_Address`=0x10 and `Data_write_Data`=0xDEADBEEF, both held afterwards. `Instruction_Write_Enable` never asserts.
- Run: A5, with `Finish_Prog` driven high 7 cycles after `core_rst_n` rises -> `core_rst_n` falls the next cycle, `done`=1, `run_cycles`=8, `timeout`=0.
- Watchdog with `MAX_RUN_CYCLES`=16 and `Finish_Prog` held 0 -> `core_rst_n` high for exactly 16 cycles, then `timeout`=1, `done`=1.
- Zero-count and error paths: A1, addr, 00 00 -> no write, back in IDLE. Then byte 0x55 -> `err`=1 and later bytes are discarded. `rst` clears `err`.
- `rst` during RUN and during a half-received word -> `core_rst_n`=0 the next cycle, no spurious write pulse, all flags 0.
